// File: rtl/ram16_seq_pkg.sv
// ============================================================================
// Module  : ram16_seq_pkg
// Brief   : Shared types and constants for the RAM16 bit-serial sequencer.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package ram16_seq_pkg;

  localparam int WR_PHASES = 3;
  localparam int BITS      = 16;

  // The write phases are contiguous so the FSM can walk them by increment.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_W_SETUP  = 3'd1,
    S_W_STROBE = 3'd2,
    S_W_HOLD   = 3'd3,
    S_R_ADDR   = 3'd4,
    S_R_SAMPLE = 3'd5,
    S_RESP     = 3'd6
  } state_t;

  function automatic logic [3:0] adr_of(input logic [3:0] init, input logic [3:0] cnt);
    return init + cnt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram16_seq_fsm.sv
// ============================================================================
// Module  : ram16_seq_fsm
// Brief   : State register, bit counter and read wait counter of the sequencer.
//           RAM16_VERIFY_EN appends a readback pass after every write.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module ram16_seq_fsm
  import ram16_seq_pkg::*;
#(
  parameter int READ_WAIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_fire,
  input  logic       i_wr,
  input  logic       i_rsp_ready,
  output state_t     o_st,
  output state_t     o_st_nxt,
  output logic [3:0] o_cnt,
  output logic [3:0] o_cnt_nxt
);

  localparam logic [3:0] c_CNT_LAST  = 4'(BITS - 1);
  localparam logic [1:0] c_WAIT_LAST = (READ_WAIT > 0) ? 2'(READ_WAIT - 1) : 2'd0;
  localparam state_t     c_RD_FIRST  = (READ_WAIT > 0) ? S_R_ADDR : S_R_SAMPLE;
  localparam state_t     c_W_LAST    = state_t'(3'(int'(S_W_SETUP) + WR_PHASES - 1));

  state_t     r_st, w_st_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [1:0] r_wait, w_wait_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st   <= S_IDLE;
      r_cnt  <= '0;
      r_wait <= '0;
    end else begin
      r_st   <= w_st_nxt;
      r_cnt  <= w_cnt_nxt;
      r_wait <= w_wait_nxt;
    end
  end

  always_comb begin
    w_st_nxt   = r_st;
    w_cnt_nxt  = r_cnt;
    w_wait_nxt = '0;
    case (r_st)
      S_IDLE: begin
        if (i_fire) begin
          w_cnt_nxt = '0;
          w_st_nxt  = i_wr ? S_W_SETUP : c_RD_FIRST;
        end
      end
      S_W_SETUP, S_W_STROBE: w_st_nxt = state_t'(r_st + 3'd1);
      c_W_LAST: begin
        if (r_cnt != c_CNT_LAST) begin
          w_cnt_nxt = r_cnt + 4'd1;
          w_st_nxt  = S_W_SETUP;
        end else begin
`ifdef RAM16_VERIFY_EN
          w_cnt_nxt = '0;
          w_st_nxt  = c_RD_FIRST;
`else
          w_st_nxt  = S_RESP;
`endif
        end
      end
      S_R_ADDR: begin
        w_wait_nxt = r_wait + 2'd1;
        if (r_wait == c_WAIT_LAST) w_st_nxt = S_R_SAMPLE;
      end
      S_R_SAMPLE: begin
        if (r_cnt == c_CNT_LAST) begin
          w_st_nxt = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
          w_st_nxt  = c_RD_FIRST;
        end
      end
      S_RESP:  if (i_rsp_ready) w_st_nxt = S_IDLE;
      default: w_st_nxt = S_IDLE;
    endcase
  end

  assign o_st      = r_st;
  assign o_st_nxt  = w_st_nxt;
  assign o_cnt     = r_cnt;
  assign o_cnt_nxt = w_cnt_nxt;

endmodule

`default_nettype wire

// File: rtl/ram16_seq_master.sv
// ============================================================================
// Module  : ram16_seq_master
// Brief   : 16-bit word host port to bit-serial X_RAM16 access, glitch-free WE.
//           Optional readback verify when RAM16_VERIFY_EN is defined.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module ram16_seq_master
  import ram16_seq_pkg::*;
#(
  parameter int         READ_WAIT = 1,
  parameter logic [3:0] INIT_ADR  = 4'h0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_WR,
  input  logic [15:0] CMD_DATA,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [15:0] RSP_DATA,
  output logic        RSP_ERR,
  output logic        ADR0,
  output logic        ADR1,
  output logic        ADR2,
  output logic        ADR3,
  output logic        I,
  output logic        WE,
  input  logic        O
);

  state_t      w_st, w_st_nxt;
  logic [3:0]  w_cnt, w_cnt_nxt;
  logic        w_fire;
  logic [15:0] w_src, w_rb;

  logic        r_cmd_ready, r_rsp_valid, r_we, r_i;
  logic [3:0]  r_adr;
  logic [15:0] r_data, r_rsp_data;
`ifdef RAM16_VERIFY_EN
  logic        r_wr, r_rsp_err;
`endif

  assign w_fire = CMD_VALID & r_cmd_ready;
  assign w_src  = (w_st == S_IDLE) ? CMD_DATA : r_data;

  always_comb begin
    w_rb        = r_rsp_data;
    w_rb[w_cnt] = O;
  end

  ram16_seq_fsm #(.READ_WAIT(READ_WAIT)) u_fsm (
    .clk         (CLK),
    .rst         (RST),
    .i_fire      (w_fire),
    .i_wr        (CMD_WR),
    .i_rsp_ready (RSP_READY),
    .o_st        (w_st),
    .o_st_nxt    (w_st_nxt),
    .o_cnt       (w_cnt),
    .o_cnt_nxt   (w_cnt_nxt)
  );

  // Outputs are computed from the next state so every pin is a flop; ADR/I
  // move only on entry to a setup/read state, never around the WE pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_we        <= 1'b0;
      r_i         <= 1'b0;
      r_adr       <= '0;
      r_data      <= '0;
      r_rsp_data  <= '0;
`ifdef RAM16_VERIFY_EN
      r_wr        <= 1'b0;
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      r_cmd_ready <= (w_st_nxt == S_IDLE);
      r_rsp_valid <= (w_st_nxt == S_RESP);
      r_we        <= (w_st_nxt == S_W_STROBE);
      if (w_fire) r_data <= CMD_DATA;
      if (w_st_nxt inside {S_W_SETUP, S_R_ADDR, S_R_SAMPLE})
        r_adr <= adr_of(INIT_ADR, w_cnt_nxt);
      if (w_st_nxt == S_W_SETUP) r_i <= w_src[w_cnt_nxt];
      if (w_st == S_R_SAMPLE) r_rsp_data <= w_rb;
`ifdef RAM16_VERIFY_EN
      if (w_fire) r_wr <= CMD_WR;
      if (w_st == S_R_SAMPLE && w_cnt == 4'(BITS - 1))
        r_rsp_err <= r_wr && (w_rb != r_data);
`else
      if (w_st == S_W_HOLD && w_st_nxt == S_RESP) r_rsp_data <= r_data;
`endif
    end
  end

  assign CMD_READY = r_cmd_ready;
  assign RSP_VALID = r_rsp_valid;
  assign RSP_DATA  = r_rsp_data;
`ifdef RAM16_VERIFY_EN
  assign RSP_ERR   = r_rsp_err;
`else
  assign RSP_ERR   = 1'b0;
`endif
  assign {ADR3, ADR2, ADR1, ADR0} = r_adr;
  assign I         = r_i;
  assign WE        = r_we;

endmodule

`default_nettype wire

// File: doc/ram16_seq_master.md
Name: ram16_seq_master

Overview:
- Initiator for the 16x1 distributed RAM primitive: drives ADR0..ADR3, I and WE, and samples O.
- Converts 16-bit parallel write/read commands on a valid/ready host interface into bit-serial RAM accesses.
- WE sequencing is glitch-free and address-safe, as required by the RAM's level-sensitive, unclocked write.
- Sits between control logic and any X_RAM16-style cell used as a 16-bit register file or shift table.

Parameters:
- READ_WAIT, 1, extra cycles ADR is held before O is sampled (legal range 0..3).
- INIT_ADR, 4'h0, first address of each burst; bursts wrap modulo 16.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- CMD_VALID  input  1  command offered.
- CMD_READY  output  1  command accepted when CMD_VALID and CMD_READY are both high on a CLK edge.
- CMD_WR  input  1  1 = write word, 0 = read word.
- CMD_DATA  input  16  write data; bit k goes to RAM address k.
- RSP_VALID  output  1  response available.
- RSP_READY  input  1  response consumed.
- RSP_DATA  output  16  read data, or echo of the written word.
- RSP_ERR  output  1  verify mismatch (only with RAM16_VERIFY_EN; otherwise tied 0).
- ADR0, ADR1, ADR2, ADR3  output  1 each  RAM address bits.
- I  output  1  RAM write data.
- WE  output  1  RAM write enable.
- O  input  1  RAM read data.

Behaviour:
- Reset:
  - All outputs are registered.
  - RST forces asynchronously: state IDLE, WE=0, ADR=0, I=0, CMD_READY=0, RSP_VALID=0, RSP_DATA=0, RSP_ERR=0.
  - CMD_READY rises on the first clock edge after RST deasserts.
  - Reset mid-burst drops WE immediately. RAM contents are then partially written; no recovery is attempted.
- States: IDLE, W_SETUP, W_STROBE, W_HOLD, R_ADDR, R_SAMPLE, RESP. A 4-bit counter cnt indexes bits 0..15; a 2-bit wait counter serves R_ADDR.
- IDLE:
  - CMD_READY=1.
  - On handshake: latch CMD_DATA and CMD_WR, set cnt=0, drive ADR=INIT_ADR, and go to W_SETUP (write) or R_ADDR (read).
- Write, per bit (3 cycles):
  - W_SETUP: ADR=INIT_ADR+cnt, I=data[cnt], WE=0.
  - W_STROBE: WE=1.
  - W_HOLD: WE=0, ADR and I unchanged.
  - ADR and I never change in the cycle WE is 1, or in the cycle WE falls.
  - After W_HOLD with cnt=15, go to RESP; otherwise cnt++ and return to W_SETUP.
  - Full write: 48 cycles from the handshake to entry into RESP.
- Read, per bit (READ_WAIT+1 cycles):
  - R_ADDR: drive ADR for READ_WAIT cycles. With READ_WAIT=0 this state is skipped.
  - R_SAMPLE: on its edge, capture RSP_DATA[cnt] <= O. cnt=15 goes to RESP.
  - WE stays 0 throughout.
  - Default read: 32 cycles.
- RESP:
  - RSP_VALID=1 and CMD_READY=0.
  - Hold RSP_DATA and RSP_ERR stable until RSP_READY, then return to IDLE.
  - Write responses echo the latched word.
- Other rules:
  - CMD_READY is 0 in every state except IDLE. No pipelining; at most one command is outstanding.
  - The address adds INIT_ADR+cnt modulo 16. With INIT_ADR=4'hC, bit 4 goes to address 0.
  - CMD_VALID is ignored while busy; held commands are accepted on the IDLE cycle.

Optional Feature:
- RAM16_VERIFY_EN defined:
  - After the last W_HOLD of a write, run a full read sequence.
  - RSP_DATA = readback word; RSP_ERR = (readback != written word).
  - Write latency becomes 48 + 16*(READ_WAIT+1) cycles.
- Undefined: no readback; RSP_ERR is a constant 0.

Decomposition:
- Package ram16_seq_pkg holds:
  - the state enum/localparams;
  - WR_PHASES=3 and BITS=16;
  - a function adr_of(init, cnt) returning a 4-bit modulo sum.
- One sub-module, ram16_seq_fsm, holds the state register, bit counter and wait counter. The top holds data/response registers and the port mapping.

Test Plan:
- Reset with RST asserted mid-W_STROBE: WE falls the same cycle without a clock edge, all outputs = 0, and CMD_READY=1 one edge after release.
- Write 16'hA5C3 into a behavioural X_RAM16 model (INIT=0): RAM mem == 16'hA5C3, response after 48 cycles, RSP_DATA=16'hA5C3. A checker flags any ADR or I change while WE=1.
- Read a model with INIT=16'h1E0F, READ_WAIT=1: RSP_DATA=16'h1E0F, RSP_VALID at cycle 32. With READ_WAIT=0: cycle 16.
- INIT_ADR=4'hC, write 16'h0001 then read back: mem bit 12 set, read returns 16'h0001.
- Backpressure: hold RSP_READY=0 for 10 cycles with CMD_VALID high. RSP_DATA stays stable, CMD_READY stays 0, and the second command is accepted the cycle after RSP_READY.
- RAM16_VERIFY_EN with O stuck-at-0, write 16'hFFFF: RSP_DATA=16'h0000, RSP_ERR=1. With a good model, RSP_ERR=0.
